// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
// Shared definitions for the control sequencer slice: opcode constants,
// instruction word field positions, write-source encodings and the FSM
// state enumeration. Imported by seq_decode and control_sequencer.
package control_sequencer_pkg;

  // Opcodes carried in bits [22:19] of the ROM word
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_MOD  = 4'd9;

  // Instruction field bit positions; Ry overlaps the top of the immediate
  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 19;
  localparam int RX_MSB  = 18;
  localparam int RX_LSB  = 16;
  localparam int RY_MSB  = 15;
  localparam int RY_LSB  = 13;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Register file write source select
  localparam logic [1:0] WR_SEL_ALU = 2'd0;
  localparam logic [1:0] WR_SEL_IMM = 2'd1;
  localparam logic [1:0] WR_SEL_RB  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_DIV,
    S_WRITE,
    S_HALT
  } state_t;

endpackage

// File: rtl/control_sequencer_seq_decode.sv
// seq_decode
// Purely combinational opcode classifier used by control_sequencer.
// Ports:
//   opcode     in  4  latched opcode from the instruction register
//   is_exec    out 1  single-cycle instruction (LOAD..AND)
//   is_div     out 1  divider instruction (DIV, MOD)
//   is_illegal out 1  opcode 10..15
//   wr_sel     out 2  register file write source for this opcode
// NOP raises none of the class flags; the FSM treats that as a halt request.
module seq_decode
  import control_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_exec,
  output logic       is_div,
  output logic       is_illegal,
  output logic [1:0] wr_sel
);

  // Default to ALU as write source so everything except LOAD/MOV writes ALU output
  always_comb begin
    is_exec    = 1'b0;
    is_div     = 1'b0;
    is_illegal = 1'b0;
    wr_sel     = WR_SEL_ALU;
    case (opcode)
      OP_NOP: ;
      OP_LOAD: begin
        is_exec = 1'b1;
        wr_sel  = WR_SEL_IMM;
      end
      OP_MOV: begin
        is_exec = 1'b1;
        wr_sel  = WR_SEL_RB;
      end
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND: is_exec = 1'b1;
      OP_DIV, OP_MOD: is_div = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Multi-cycle instruction sequencer: fetches a 23-bit word from an external
// ROM, decodes it, drives register-file and divider control, and advances pc.
// Optional feature macro: SINGLE_STEP_EN adds a 'step' input; each rising
// edge of step runs one instruction, after which the FSM returns to IDLE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 level start request
//   step                (SINGLE_STEP_EN only) single-step trigger
//   pc, code            ROM address out, ROM word in
//   rf_rd_a, rf_rd_b    register read addresses (Rx, Ry)
//   rf_wr_en/addr       one-cycle write strobe, write address (Rx)
//   wr_sel, imm, alu_op write source, latched immediate, latched opcode
//   div_start, div_done divider handshake
//   busy, halted, err   status; err is sticky until HALT exit or reset
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int DIV_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [4:0]  pc,
  input  logic [22:0] code,
  output logic [2:0]  rf_rd_a,
  output logic [2:0]  rf_rd_b,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [1:0]  wr_sel,
  output logic [15:0] imm,
  output logic [3:0]  alu_op,
  output logic        div_start,
  input  logic        div_done,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    rx_q;
  logic [CW-1:0] tmo_cnt;
  logic          done_seen;
  logic          div_ready;
  logic          tmo_hit;
  logic          start_req;
  logic          go_on;
  logic          halt_exit;
  logic          dec_exec;
  logic          dec_div;
  logic          dec_illegal;

  seq_decode u_decode (
    .opcode     (alu_op),
    .is_exec    (dec_exec),
    .is_div     (dec_div),
    .is_illegal (dec_illegal),
    .wr_sel     (wr_sel)
  );

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Remember last step level so only its rising edge starts an instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign start_req = step & ~step_q;
  assign go_on     = 1'b0;
`else
  assign start_req = run;
  assign go_on     = run;
`endif

  // A done pulse seen any time since div_start (including that cycle) is enough
  assign div_ready = done_seen | div_done;
  assign tmo_hit   = (state == S_WAIT_DIV) && !div_ready &&
                     (tmo_cnt >= CW'(DIV_TIMEOUT - 1));
  assign halt_exit = (state == S_HALT) && !run;

  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);
  assign rf_rd_a    = rx_q;
  assign rf_rd_b    = imm[RY_MSB:RY_LSB];
  assign rf_wr_addr = rx_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe outputs; NOP and illegal opcodes both end in HALT
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    rf_wr_en  = 1'b0;
    case (state)
      S_IDLE:   if (start_req) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_exec) begin
          state_nxt = S_EXEC;
        end else if (dec_div) begin
          state_nxt = S_EXEC;
          div_start = 1'b1;
        end else begin
          state_nxt = S_HALT;
        end
      end
      S_EXEC:   state_nxt = dec_div ? S_WAIT_DIV : S_WRITE;
      S_WAIT_DIV: begin
        if (div_ready)    state_nxt = S_WRITE;
        else if (tmo_hit) state_nxt = S_HALT;
      end
      S_WRITE: begin
        rf_wr_en  = 1'b1;
        state_nxt = go_on ? S_FETCH : S_IDLE;
      end
      S_HALT:   if (!run) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Instruction register, loaded from the ROM word at the end of FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      rx_q   <= '0;
      imm    <= '0;
    end else if (state == S_FETCH) begin
      alu_op <= code[OPC_MSB:OPC_LSB];
      rx_q   <= code[RX_MSB:RX_LSB];
      imm    <= code[IMM_MSB:IMM_LSB];
    end
  end

  // Program counter: advance on every write, rewind when leaving HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pc <= '0;
    else if (state == S_WRITE) pc <= pc + 5'd1;
    else if (halt_exit)        pc <= '0;
  end

  // Sticky fault flag, cleared only on the HALT-to-IDLE transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err <= 1'b0;
    else if (halt_exit)                             err <= 1'b0;
    else if ((state == S_DECODE && dec_illegal) || tmo_hit) err <= 1'b1;
  end

  // Divider wait bookkeeping: counter and done flag restart in the div_start cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      done_seen <= 1'b0;
    end else if (state == S_DECODE) begin
      tmo_cnt   <= '0;
      done_seen <= div_done;
    end else if (state == S_EXEC || state == S_WAIT_DIV) begin
      tmo_cnt   <= tmo_cnt + CW'(1);
      done_seen <= done_seen | div_done;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed bench for control_sequencer (default build, SINGLE_STEP_EN undefined).
// Each scenario is expressed as a list of per-cycle records built from the
// instruction-level rules (4 cycles per instruction, N extra divider waits,
// HALT on NOP/illegal/timeout); a compare process checks the DUT every cycle.
module tb_control_sequencer;

  localparam int DIV_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        div_done = 1'b0;
  logic [4:0]  pc;
  logic [22:0] code;
  logic [2:0]  rf_rd_a, rf_rd_b, rf_wr_addr;
  logic        rf_wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] imm;
  logic [3:0]  alu_op;
  logic        div_start, busy, halted, err;

  logic [22:0] rom [32];
  assign code = rom[pc];

  always #5 clk = ~clk;

  control_sequencer #(.DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .pc         (pc),
    .code       (code),
    .rf_rd_a    (rf_rd_a),
    .rf_rd_b    (rf_rd_b),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .wr_sel     (wr_sel),
    .imm        (imm),
    .alu_op     (alu_op),
    .div_start  (div_start),
    .div_done   (div_done),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  // One cycle of stimulus plus what the outputs must be during that cycle
  typedef struct {
    bit          chk;
    bit          run;
    bit          done;
    bit          busy;
    bit          halted;
    bit          wr;
    bit          ds;
    bit          errv;
    logic [4:0]  pc;
    bit          chkRd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  wa;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [3:0]  op;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;

  int testsRun = 0;
  int failures = 0;
  int busyCnt = 0;
  int wrCnt = 0;
  int dsCnt = 0;
  logic [2:0] lastWrAddr = '0;
  logic [1:0] lastWrSel = '0;

  int mPc = 0;
  bit mErr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t blank(input bit runv);
    cyc_t e;
    e = '{default: '0};
    e.chk  = 1'b1;
    e.run  = runv;
    e.pc   = 5'(mPc);
    e.errv = mErr;
    return e;
  endfunction

  task automatic pushIdle(input bit runv);
    q.push_back(blank(runv));
  endtask

  // Expected trace of one instruction. doneAt: -1 never, 0 in the div_start
  // cycle, k>=1 in the k-th divider wait cycle.
  task automatic modelInstr(input logic [22:0] w, input int doneAt, input bit midRun, input bit runAfter);
    cyc_t e;
    logic [3:0] op;
    int nWait;
    op = w[22:19];
    e = blank(midRun); e.busy = 1; q.push_back(e);
    e = blank(midRun); e.busy = 1; e.chkRd = 1; e.ra = w[18:16]; e.rb = w[15:13];
    e.ds = (op == 4'd8 || op == 4'd9); e.done = (e.ds && doneAt == 0);
    q.push_back(e);
    if (op == 4'd0 || op >= 4'd10) begin
      if (op >= 4'd10) mErr = 1'b1;
      return;
    end
    e = blank(midRun); e.busy = 1; q.push_back(e);
    if (op >= 4'd8) begin
      nWait = (doneAt < 0) ? DIV_TIMEOUT - 1 : ((doneAt == 0) ? 1 : doneAt);
      for (int k = 1; k <= nWait; k++) begin
        e = blank(midRun); e.busy = 1; e.done = (doneAt == k); q.push_back(e);
      end
      if (doneAt < 0) begin
        mErr = 1'b1;
        return;
      end
    end
    e = blank(runAfter); e.busy = 1; e.wr = 1; e.wa = w[18:16];
    e.sel = (op == 4'd1) ? 2'd1 : ((op == 4'd2) ? 2'd2 : 2'd0);
    e.imm = w[15:0]; e.op = op;
    q.push_back(e);
    mPc = (mPc + 1) % 32;
    if (!runAfter) pushIdle(1'b0);
  endtask

  task automatic haltHold(input int n);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(1'b1); e.halted = 1; q.push_back(e);
    end
  endtask

  task automatic haltRelease();
    cyc_t e;
    e = blank(1'b0); e.halted = 1; q.push_back(e);
    mPc = 0;
    mErr = 1'b0;
    pushIdle(1'b0);
  endtask

  // Play the queued cycles: drive inputs just after each rising edge
  task automatic applyStimulus();
    while (q.size() > 0) begin
      @(posedge clk); #2;
      cur = q.pop_front();
      run = cur.run;
      div_done = cur.done;
      @(negedge clk); #1;
    end
    cur.chk = 1'b0;
  endtask

  task automatic doReset();
    cur.chk = 1'b0;
    rst_n = 1'b0; run = 1'b0; div_done = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mPc = 0; mErr = 1'b0;
    @(negedge clk); #1;
    busyCnt = 0; wrCnt = 0; dsCnt = 0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 32; i++) rom[i] = 23'h0;
  endtask

  // Compare process: observed activity counters plus per-cycle model checks
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busyCnt++;
      if (div_start) dsCnt++;
      if (rf_wr_en) begin
        wrCnt++;
        lastWrAddr = rf_wr_addr;
        lastWrSel = wr_sel;
      end
    end
    if (cur.chk) begin
      checkOutput("busy", 32'(busy), 32'(cur.busy));
      checkOutput("halted", 32'(halted), 32'(cur.halted));
      checkOutput("rf_wr_en", 32'(rf_wr_en), 32'(cur.wr));
      checkOutput("div_start", 32'(div_start), 32'(cur.ds));
      checkOutput("err", 32'(err), 32'(cur.errv));
      checkOutput("pc", 32'(pc), 32'(cur.pc));
      if (cur.chkRd) begin
        checkOutput("rf_rd_a", 32'(rf_rd_a), 32'(cur.ra));
        checkOutput("rf_rd_b", 32'(rf_rd_b), 32'(cur.rb));
      end
      if (cur.wr) begin
        checkOutput("rf_wr_addr", 32'(rf_wr_addr), 32'(cur.wa));
        checkOutput("wr_sel", 32'(wr_sel), 32'(cur.sel));
        checkOutput("imm", 32'(imm), 32'(cur.imm));
        checkOutput("alu_op", 32'(alu_op), 32'(cur.op));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cur = '{default: '0};
    clearRom();
    doReset();
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);

    // LOAD R3, 0x0014 at pc 0
    rom[0] = {4'd1, 3'd3, 16'h0014};
    pushIdle(1'b1);
    modelInstr(rom[0], -1, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("load_pc", 32'(pc), 32'd1);
    checkOutput("load_imm", 32'(imm), 32'h14);
    checkOutput("load_busy_cycles", busyCnt, 32'd4);
    checkOutput("load_wr_addr", 32'(lastWrAddr), 32'd3);
    checkOutput("load_wr_sel", 32'(lastWrSel), 32'd1);

    // MOV R5,R7 then ADD R3,R0; run dropped mid-ADD must not abort it
    doReset(); clearRom();
    rom[0] = {4'd2, 3'd5, 3'd7, 13'd0};
    rom[1] = {4'd3, 3'd3, 16'h0000};
    pushIdle(1'b1);
    modelInstr(rom[0], -1, 1'b1, 1'b1);
    modelInstr(rom[1], -1, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("movadd_pc", 32'(pc), 32'd2);
    checkOutput("movadd_busy_cycles", busyCnt, 32'd8);
    checkOutput("movadd_writes", wrCnt, 32'd2);
    checkOutput("movadd_alu_op", 32'(alu_op), 32'd3);

    // DIV R2,R5 with done in the 6th wait cycle
    doReset(); clearRom();
    rom[0] = {4'd8, 3'd2, 3'd5, 13'd0};
    pushIdle(1'b1);
    modelInstr(rom[0], 6, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("div_busy_cycles", busyCnt, 32'd10);
    checkOutput("div_start_pulses", dsCnt, 32'd1);
    checkOutput("div_wr_addr", 32'(lastWrAddr), 32'd2);

    // Remainder instruction (opcode 9) with done arriving in the div_start cycle
    doReset(); clearRom();
    rom[0] = {4'd9, 3'd6, 3'd1, 13'd0};
    pushIdle(1'b1);
    modelInstr(rom[0], 0, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("mod_early_busy_cycles", busyCnt, 32'd5);

    // DIV with no done: timeout, HALT entered at cycle 3 + DIV_TIMEOUT
    doReset(); clearRom();
    rom[0] = {4'd8, 3'd2, 3'd5, 13'd0};
    pushIdle(1'b1);
    modelInstr(rom[0], -1, 1'b1, 1'b1);
    haltHold(2);
    applyStimulus();
    checkOutput("tmo_busy_cycles", busyCnt, 32'd34);
    checkOutput("tmo_writes", wrCnt, 32'd0);
    checkOutput("tmo_err", 32'(err), 32'd1);
    haltRelease();
    applyStimulus();
    checkOutput("tmo_release_err", 32'(err), 32'd0);

    // Illegal opcode 0xC
    doReset(); clearRom();
    rom[0] = {4'hC, 3'd1, 16'h0000};
    pushIdle(1'b1);
    modelInstr(rom[0], -1, 1'b1, 1'b1);
    haltHold(3);
    applyStimulus();
    checkOutput("illegal_err", 32'(err), 32'd1);
    checkOutput("illegal_halted", 32'(halted), 32'd1);
    checkOutput("illegal_writes", wrCnt, 32'd0);
    haltRelease();
    applyStimulus();
    checkOutput("illegal_release_halted", 32'(halted), 32'd0);

    // 18 LOADs then NOP at pc 18
    doReset(); clearRom();
    for (int i = 0; i < 18; i++) rom[i] = {4'd1, 3'(i % 8), 16'(i * 3)};
    pushIdle(1'b1);
    for (int i = 0; i < 19; i++) modelInstr(rom[i], -1, 1'b1, 1'b1);
    haltHold(2);
    applyStimulus();
    checkOutput("nop_halt_pc", 32'(pc), 32'd18);
    checkOutput("nop_halted", 32'(halted), 32'd1);
    checkOutput("nop_err", 32'(err), 32'd0);
    haltRelease();
    applyStimulus();
    checkOutput("nop_release_pc", 32'(pc), 32'd0);

    // 32 consecutive LOADs: pc wraps from 31 to 0
    doReset(); clearRom();
    for (int i = 0; i < 32; i++) rom[i] = {4'd1, 3'(i % 8), 16'(16'h100 + i)};
    pushIdle(1'b1);
    for (int i = 0; i < 32; i++) modelInstr(rom[i], -1, 1'b1, (i != 31));
    applyStimulus();
    checkOutput("wrap_writes", wrCnt, 32'd32);
    checkOutput("wrap_pc", 32'(pc), 32'd0);

    // Reset asserted in the third divider wait cycle of DIV at pc 1
    doReset(); clearRom();
    rom[0] = {4'd1, 3'd1, 16'h1234};
    rom[1] = {4'd8, 3'd2, 3'd5, 13'd0};
    pushIdle(1'b1);
    modelInstr(rom[0], -1, 1'b1, 1'b1);
    modelInstr(rom[1], -1, 1'b1, 1'b1);
    q = q[0:10];
    applyStimulus();
    checkOutput("prereset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_imm", 32'(imm), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_wr_sel", 32'(wr_sel), 32'd0);
    checkOutput("rst_wr_en", 32'(rf_wr_en), 32'd0);
    checkOutput("rst_div_start", 32'(div_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    run = 1'b0; div_done = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    mPc = 0; mErr = 1'b0;
    pushIdle(1'b0);
    pushIdle(1'b0);
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 32: maximum cycles to wait for div_done.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port run, input, 1: start request, level-sensitive.
REQ-005 SHALL have port pc, output, 5: instruction ROM address.
REQ-006 SHALL have port code, input, 23: ROM word; fields are [22:19] opcode, [18:16] Rx, [15:13] Ry, [15:0] imm.
REQ-007 SHALL have port rf_rd_a, output, 3: register file read address A, driven with Rx.
REQ-008 SHALL have port rf_rd_b, output, 3: register file read address B, driven with Ry.
REQ-009 SHALL have port rf_wr_en, output, 1: one-cycle register write strobe.
REQ-010 SHALL have port rf_wr_addr, output, 3: write address, driven with Rx.
REQ-011 SHALL have port wr_sel, output, 2: write source; 0 = ALU, 1 = imm, 2 = read port B.
REQ-012 SHALL have port imm, output, 16: latched immediate.
REQ-013 SHALL have port alu_op, output, 4: latched opcode.
REQ-014 SHALL have port div_start, output, 1: divider start pulse.
REQ-015 SHALL have port div_done, input, 1: divider result valid.
REQ-016 SHALL have port busy, output, 1: high in any state except IDLE and HALT.
REQ-017 SHALL have port halted, output, 1: high in HALT.
REQ-018 SHALL have port err, output, 1: sticky fault flag (illegal opcode or divider timeout).

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXEC, WAIT_DIV, WRITE and HALT.
- IDLE goes to FETCH when run = 1.
- FETCH latches code into the instruction register at the end of the cycle, then goes to DECODE.
REQ-020 DECODE SHALL drive rf_rd_a/rf_rd_b from the instruction register and dispatch on the opcode:
- 0 goes to HALT.
- 1 to 7 go to EXEC.
- 8 and 9 go to EXEC with div_start high for exactly one cycle.
- 10 to 15 set err and go to HALT.
REQ-021 EXEC SHALL go to WRITE for opcodes 1 to 7, and to WAIT_DIV for opcodes 8 and 9.
REQ-022 WAIT_DIV SHALL go to WRITE on the cycle after div_done = 1; div_done arriving in the div_start cycle counts.
REQ-023 The timeout counter SHALL clear on div_start; if DIV_TIMEOUT cycles elapse without div_done, err is set and the FSM goes to HALT with no write.
REQ-024 WRITE SHALL assert rf_wr_en for one cycle with rf_wr_addr = Rx and this write source:
- opcode 1: wr_sel = 1.
- opcode 2: wr_sel = 2.
- opcodes 3 to 9: wr_sel = 0.
REQ-025 WRITE SHALL increment pc modulo 32 (31 wraps to 0) and go to FETCH if run = 1, otherwise to IDLE.
REQ-026 Latency SHALL be 4 cycles per instruction for opcodes 1 to 7, and 4 + N cycles for DIV/MOD, where N is the number of WAIT_DIV cycles.
REQ-027 A run deassertion mid-instruction SHALL NOT abort the instruction; it is sampled only in IDLE and WRITE.
REQ-028 HALT SHALL hold pc, and SHALL go to IDLE with pc = 0 on the cycle after run = 0; err clears only on that transition or on reset.
REQ-029 rf_wr_en and div_start SHALL never be high together, and neither is high outside WRITE and DECODE respectively.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and clear all registered state and outputs, whatever the current state, including mid-WAIT_DIV:
- pc = 0, imm = 0, alu_op = 0, wr_sel = 0.
- rf_wr_en, div_start, busy, halted and err = 0.
REQ-031 Reset release SHALL be recognised on the first rising clk edge after rst_n goes high.

Configuration
REQ-032 With SINGLE_STEP_EN defined, SHALL add input step (1 bit): WRITE goes to IDLE regardless of run, and IDLE goes to FETCH only on a rising edge of step.
REQ-033 Without SINGLE_STEP_EN, the step port SHALL be absent and behaviour is as in REQ-025.

Structure
REQ-034 A shared package SHALL hold the opcode constants (NOP, LOAD, MOV, ADD, SUB, XOR, OR, AND, DIV, MOD = 0 to 9), the instruction field bit positions, the wr_sel encodings and the state enumeration.
REQ-035 The opcode-to-control mapping SHALL be one combinational sub-module, seq_decode; the FSM, pc and timeout counter stay in control_sequencer.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- LOAD: code = {1, R3, 0x0014} at pc 0 with run = 1 -> rf_wr_en in cycle 4 with rf_wr_addr = 3, wr_sel = 1, imm = 0x0014; pc = 1.
- MOV then ADD: MOV R5,R7 then ADD R3,R0 -> first write wr_sel = 2, addr 5; second write wr_sel = 0, alu_op = 3, addr 3; pc = 2 after 8 cycles.
- DIV: DIV R2,R5 with div_done after 6 cycles -> single div_start pulse, write 1 cycle after div_done, total 10 cycles; with div_done never asserted -> err = 1 and HALT at cycle 3 + 32, no write.
- Illegal and halt: opcode 0xC -> err = 1, halted = 1, no write; opcode 0 at pc 18 -> halted = 1, pc = 18; run 0 -> IDLE with pc = 0 and err = 0.
- Wrap and reset: 32 consecutive LOADs -> pc wraps 31 to 0; rst_n pulsed low during WAIT_DIV -> all outputs 0 immediately, IDLE.
